max7219_serial_tx: RTL and testbench

MAX7219_SERIAL_TX -- requirements
Module: max7219_serial_tx

---
 rtl/max7219_serial_tx.sv | 154 +++++++++++++++
 tb/tb_max7219_serial_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_serial_tx.sv
// MAX7219 serial transmitter: shifts one 16-bit frame MSB first on a
// divided serial clock, then pulses the load strobe so the driver latches it.
// All outputs are registered; the frame is captured once at accept.
module max7219_serial_tx #(
  parameter int HALF_PERIOD = 2  // serial clock half period in i_clk cycles, 1..255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_serial_dout,
  output logic        o_serial_clk,
  output logic        o_serial_load,
  output logic        o_done
);

  // Half-period counter only has to reach HALF_PERIOD-1; keep at least one bit.
  localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] HP_LAST = CNT_W'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LOAD
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      shift_q, shift_d;
  logic [3:0]       bit_q, bit_d;
  logic [CNT_W-1:0] hp_q, hp_d;
  logic             ready_q, ready_d;
  logic             dout_q, dout_d;
  logic             sclk_q, sclk_d;
  logic             load_q, load_d;
  logic             done_q, done_d;

  logic hp_end;
  assign hp_end = (hp_q == HP_LAST);

  // State and output registers; reset returns everything to an idle, empty frame.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (i_reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      hp_q    <= '0;
      ready_q <= 1'b1;
      dout_q  <= 1'b0;
      sclk_q  <= 1'b0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      hp_q    <= hp_d;
      ready_q <= ready_d;
      dout_q  <= dout_d;
      sclk_q  <= sclk_d;
      load_q  <= load_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic for the shift/load sequence.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    hp_d    = hp_q;
    ready_d = ready_q;
    dout_d  = dout_q;
    sclk_d  = sclk_q;
    load_d  = load_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          state_d = SHIFT_LO;
          shift_d = i_data;
          dout_d  = i_data[15];
          bit_d   = '0;
          hp_d    = '0;
          ready_d = 1'b0;
          sclk_d  = 1'b0;
        end
      end

      SHIFT_LO: begin
        if (hp_end) begin
          state_d = SHIFT_HI;
          hp_d    = '0;
          sclk_d  = 1'b1;
        end else begin
          hp_d = hp_q + 1'b1;
        end
      end

      SHIFT_HI: begin
        if (hp_end) begin
          hp_d   = '0;
          sclk_d = 1'b0;
          if (bit_q == 4'd15) begin
            // Last bit sampled: park data low and raise the latch strobe.
            state_d = LOAD;
            load_d  = 1'b1;
            dout_d  = 1'b0;
          end else begin
            // Data changes together with the falling serial clock.
            state_d = SHIFT_LO;
            shift_d = {shift_q[14:0], 1'b0};
            dout_d  = shift_q[14];
            bit_d   = bit_q + 4'd1;
          end
        end else begin
          hp_d = hp_q + 1'b1;
        end
      end

      LOAD: begin
        if (hp_end) begin
          state_d = IDLE;
          hp_d    = '0;
          bit_d   = '0;
          load_d  = 1'b0;
          done_d  = 1'b1;
          ready_d = 1'b1;
        end else begin
          hp_d = hp_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        sclk_d  = 1'b0;
        load_d  = 1'b0;
        dout_d  = 1'b0;
      end
    endcase
  end

  assign o_ready       = ready_q;
  assign o_serial_dout = dout_q;
  assign o_serial_clk  = sclk_q;
  assign o_serial_load = load_q;
  assign o_done        = done_q;

endmodule

// File: tb/tb_max7219_serial_tx.sv
// Directed bench for max7219_serial_tx: one instance at HALF_PERIOD=2, one at
// HALF_PERIOD=1, each observed by a MAX7219 receiver mock and protocol monitor.
module tb_max7219_serial_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  vld;
  logic [15:0] data0, data1;
  logic [1:0]  ready, dout, sclk, load, done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  max7219_serial_tx #(.HALF_PERIOD(2)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_data(data0), .i_valid(vld[0]),
    .o_ready(ready[0]), .o_serial_dout(dout[0]), .o_serial_clk(sclk[0]),
    .o_serial_load(load[0]), .o_done(done[0])
  );

  max7219_serial_tx #(.HALF_PERIOD(1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_data(data1), .i_valid(vld[1]),
    .o_ready(ready[1]), .o_serial_dout(dout[1]), .o_serial_clk(sclk[1]),
    .o_serial_load(load[1]), .o_done(done[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int hp_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  // Receiver mock and per-cycle protocol monitor state.
  logic [15:0] sr [2];
  logic [15:0] latched [2][8];
  int          acc_hist [2][8];
  int          nload [2];
  int          nacc [2];
  int          ndone [2];
  int          rises [2];
  int          hi [2];
  int          acc_cyc [2];
  int          load_start [2];
  logic [1:0]  busy = '0;
  logic [1:0]  prev_sclk = '0, prev_load = '0, prev_dout = '0, prev_done = '0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      sr[k] = '0; nload[k] = 0; nacc[k] = 0; ndone[k] = 0;
      rises[k] = 0; hi[k] = 0; acc_cyc[k] = 0; load_start[k] = 0;
    end
  end

  // Samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (sclk[k] && prev_sclk[k]) check("dout_stable_clk_high", 32'(dout[k]), 32'(prev_dout[k]));
      if (load[k]) check("clk_low_in_load", 32'(sclk[k]), 32'd0);
      if (done[k]) begin
        busy[k] = 1'b0;
        ndone[k]++;
        check("done_follows_load", 32'(prev_load[k]), 32'd1);
        check("done_one_cycle", 32'(prev_done[k]), 32'd0);
      end
      check("ready_only_idle", 32'(ready[k]), 32'(!busy[k]));
      if (ready[k]) check("idle_clk_low", 32'(sclk[k]), 32'd0);
      if (sclk[k] && !prev_sclk[k]) begin
        sr[k] = {sr[k][14:0], dout[k]};
        rises[k]++;
      end
      if (sclk[k]) hi[k]++;
      if (load[k] && !prev_load[k]) begin
        check("clk_rises_per_frame", 32'(rises[k]), 32'd16);
        check("clk_high_cycles", 32'(hi[k]), 32'(16 * hp_of(k)));
        check("load_latency", 32'(cyc - acc_cyc[k]), 32'(1 + 32 * hp_of(k)));
        if (nload[k] < 8) latched[k][nload[k]] = sr[k];
        nload[k]++;
        load_start[k] = cyc;
      end
      if (!load[k] && prev_load[k]) begin
        check("load_width", 32'(cyc - load_start[k]), 32'(hp_of(k)));
        check("done_at_load_fall", 32'(done[k]), 32'd1);
      end
      if (rst) begin
        busy[k] = 1'b0;
      end else if (ready[k] && vld[k]) begin
        busy[k] = 1'b1;
        acc_cyc[k] = cyc;
        if (nacc[k] < 8) acc_hist[k][nacc[k]] = cyc;
        nacc[k]++;
        rises[k] = 0;
        hi[k] = 0;
      end
      prev_sclk[k] = sclk[k];
      prev_load[k] = load[k];
      prev_dout[k] = dout[k];
      prev_done[k] = done[k];
    end
  end

  task automatic set_data(input int k, input logic [15:0] d);
    if (k == 0) data0 = d;
    else data1 = d;
  endtask

  task automatic wait_acc(input int k, input int tgt);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (nacc[k] >= tgt) break;
    end
    check("accept_seen", 32'(nacc[k] >= tgt), 32'd1);
  endtask

  task automatic wait_done(input int k);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (done[k]) break;
    end
    check("done_seen", 32'(done[k]), 32'd1);
  endtask

  task automatic wait_rises(input int k, input int n);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (rises[k] >= n) break;
    end
    check("rises_reached", 32'(rises[k] >= n), 32'd1);
  endtask

  task automatic send(input int k, input logic [15:0] d);
    int tgt;
    @(posedge clk); #1;
    vld[k] = 1'b1;
    set_data(k, d);
    tgt = nacc[k] + 1;
    wait_acc(k, tgt);
    @(posedge clk); #1;
    vld[k] = 1'b0;
  endtask

  task automatic check_idle(input int k, input string tag);
    check({tag, "_ready"}, 32'(ready[k]), 32'd1);
    check({tag, "_sclk"},  32'(sclk[k]),  32'd0);
    check({tag, "_load"},  32'(load[k]),  32'd0);
    check({tag, "_dout"},  32'(dout[k]),  32'd0);
    check({tag, "_done"},  32'(done[k]),  32'd0);
  endtask

  int b, bl;

  initial begin
    rst = 1'b1; vld = '0; data0 = '0; data1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    check_idle(0, "reset0");
    check_idle(1, "reset1");

    // Single frame 0x0C01 at HALF_PERIOD=2.
    bl = nload[0];
    send(0, 16'h0C01);
    wait_done(0);
    check("t1_loads", 32'(nload[0]), 32'(bl + 1));
    check("t1_latched", 32'(latched[0][bl]), 32'h0C01);
    check("t1_done_count", 32'(ndone[0]), 32'd1);

    // Back-to-back frames with i_valid held high.
    bl = nload[0]; b = nacc[0];
    @(posedge clk); #1;
    vld[0] = 1'b1; data0 = 16'h0900;
    wait_acc(0, b + 1);
    @(posedge clk); #1;
    data0 = 16'h0A0F;
    wait_acc(0, b + 2);
    @(posedge clk); #1;
    vld[0] = 1'b0;
    wait_done(0);
    check("t2_period", 32'(acc_hist[0][b + 1] - acc_hist[0][b]), 32'd67);
    check("t2_first", 32'(latched[0][bl]), 32'h0900);
    check("t2_second", 32'(latched[0][bl + 1]), 32'h0A0F);

    // Reset after the 8th serial clock rise; valid on the other instance during reset.
    bl = nload[0]; b = nacc[1];
    send(0, 16'h0B07);
    wait_rises(0, 8);
    @(posedge clk); #1;
    rst = 1'b1; vld[1] = 1'b1; data1 = 16'h1234;
    @(posedge clk); #1;
    rst = 1'b0; vld[1] = 1'b0;
    @(negedge clk); #1;
    check_idle(0, "t3_abort");
    check("t3_valid_in_reset_ready", 32'(ready[1]), 32'd1);
    check("t3_valid_in_reset_acc", 32'(nacc[1]), 32'(b));
    repeat (80) @(posedge clk);
    #1;
    check("t3_no_load", 32'(nload[0]), 32'(bl));
    send(0, 16'h0B07);
    wait_done(0);
    check("t3_resend", 32'(latched[0][bl]), 32'h0B07);

    // Data and valid disturbed mid-frame.
    bl = nload[0]; b = nacc[0];
    send(0, 16'h0100);
    wait_rises(0, 3);
    @(posedge clk); #1;
    data0 = 16'hFFFF; vld[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1 vld[0] = 1'b0;
    wait_done(0);
    check("t4_latched", 32'(latched[0][bl]), 32'h0100);
    repeat (80) @(posedge clk);
    #1;
    check("t4_one_load", 32'(nload[0]), 32'(bl + 1));
    check("t4_one_accept", 32'(nacc[0]), 32'(b + 1));

    // HALF_PERIOD=1 back-to-back 0xFFFF then 0x0000.
    bl = nload[1]; b = nacc[1];
    @(posedge clk); #1;
    vld[1] = 1'b1; data1 = 16'hFFFF;
    wait_acc(1, b + 1);
    @(posedge clk); #1;
    data1 = 16'h0000;
    wait_acc(1, b + 2);
    @(posedge clk); #1;
    vld[1] = 1'b0;
    wait_done(1);
    check("t5_period", 32'(acc_hist[1][b + 1] - acc_hist[1][b]), 32'd34);
    check("t5_first", 32'(latched[1][bl]), 32'hFFFF);
    check("t5_second", 32'(latched[1][bl + 1]), 32'h0000);
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
